// File: rtl/axi_stream_buffer.sv
// N-deep registered AXI4-Stream buffer with optional store-and-forward packet mode,
// synchronous flush and fill/packet-count status. No combinational path from rx to tx.

package axi_stream_buffer_pkg;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  dest;
        logic [3:0]  user;
    } s_chan_t;

    typedef struct packed {
        s_chan_t t;
        logic    tvalid;
    } axi_stream_req_t;

    typedef struct packed {
        logic tready;
    } axi_stream_rsp_t;

endpackage

module axi_stream_buffer_checker #(
    parameter int unsigned Depth    = 2,
    parameter int unsigned CntWidth = 2,
    parameter int unsigned TWidth   = 1
) (
    input logic                clk_i,
    input logic                rst_ni,
    input logic                flush_i,
    input logic                rx_valid_i,
    input logic                rx_ready_i,
    input logic [TWidth-1:0]   rx_t_i,
    input logic                tx_valid_i,
    input logic                tx_ready_i,
    input logic [TWidth-1:0]   tx_t_i,
    input logic [CntWidth-1:0] usage_i,
    input logic [CntWidth-1:0] pkt_cnt_i
);

    a_depth_min: assert property (@(posedge clk_i) Depth >= 32'd2)
        else $error("axi_stream_buffer: Depth must be at least 2");

    a_rx_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rx_valid_i && !rx_ready_i) |=> (rx_valid_i && $stable(rx_t_i)))
        else $error("axi_stream_buffer: rx beat changed while stalled");

    a_tx_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (tx_valid_i && !tx_ready_i && !flush_i) |=> (tx_valid_i && $stable(tx_t_i)))
        else $error("axi_stream_buffer: tx beat changed while stalled");

    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (usage_i <= CntWidth'(Depth)) && (pkt_cnt_i <= usage_i))
        else $error("axi_stream_buffer: status counter out of range");

endmodule

module axi_stream_buffer #(
    parameter int unsigned Depth            = 2,
    parameter bit          PacketMode       = 1'b0,
    parameter type         s_chan_t         = axi_stream_buffer_pkg::s_chan_t,
    parameter type         axi_stream_req_t = axi_stream_buffer_pkg::axi_stream_req_t,
    parameter type         axi_stream_rsp_t = axi_stream_buffer_pkg::axi_stream_rsp_t,
    parameter int unsigned CntWidth         = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  axi_stream_req_t     rx_req_i,
    output axi_stream_rsp_t     rx_rsp_o,
    output axi_stream_req_t     tx_req_o,
    input  axi_stream_rsp_t     tx_rsp_i,
    output logic [CntWidth-1:0] usage_o,
    output logic [CntWidth-1:0] pkt_cnt_o
);

    localparam int unsigned PtrWidth = (Depth > 32'd1) ? $clog2(Depth) : 32'd1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 32'd1);

    s_chan_t               mem_q [Depth];
    s_chan_t               mem_d [Depth];
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntWidth-1:0]   usage_q, usage_d;
    logic [CntWidth-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic                  rdy_en_q, rdy_en_d;

    logic                  full_s;
    logic                  empty_s;
    logic                  tready_s;
    logic                  tvalid_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  push_last_s;
    logic                  pop_last_s;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        logic [PtrWidth-1:0] nxt;
        if (ptr == LastPtr) begin
            nxt = {PtrWidth{1'b0}};
        end else begin
            nxt = ptr + PtrWidth'(1);
        end
        return nxt;
    endfunction

    // Handshake qualification from registered state only; rdy_en_q holds tready low through reset.
    always_comb begin
        full_s   = (usage_q == DepthCnt);
        empty_s  = (usage_q == {CntWidth{1'b0}});
        tready_s = rdy_en_q & ~full_s & ~flush_i;
        if (PacketMode) begin
            // A full buffer with no complete packet streams cut-through to avoid deadlock.
            tvalid_s = ~empty_s & ((pkt_cnt_q != {CntWidth{1'b0}}) | full_s);
        end else begin
            tvalid_s = ~empty_s;
        end
        push_s      = rx_req_i.tvalid & tready_s;
        pop_s       = tvalid_s & tx_rsp_i.tready;
        push_last_s = push_s & rx_req_i.t.last;
        pop_last_s  = pop_s & mem_q[rd_ptr_q].last;
    end

    // Port outputs: tx beat read straight from storage at the read pointer.
    always_comb begin
        tx_req_o        = '0;
        tx_req_o.t      = mem_q[rd_ptr_q];
        tx_req_o.tvalid = tvalid_s;
        rx_rsp_o        = '0;
        rx_rsp_o.tready = tready_s;
        usage_o         = usage_q;
        pkt_cnt_o       = pkt_cnt_q;
    end

    // Next-state for storage, pointers and counters; flush overrides everything but storage.
    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        usage_d   = usage_q;
        pkt_cnt_d = pkt_cnt_q;
        rdy_en_d  = 1'b1;

        if (push_s) begin
            mem_d[wr_ptr_q] = rx_req_i.t;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   usage_d = usage_q + CntWidth'(1);
            2'b01:   usage_d = usage_q - CntWidth'(1);
            default: usage_d = usage_q;
        endcase

        case ({push_last_s, pop_last_s})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CntWidth'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - CntWidth'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase

        if (flush_i) begin
            rd_ptr_d  = {PtrWidth{1'b0}};
            wr_ptr_d  = {PtrWidth{1'b0}};
            usage_d   = {CntWidth{1'b0}};
            pkt_cnt_d = {CntWidth{1'b0}};
        end else begin
            pkt_cnt_d = pkt_cnt_d;
        end
    end

    // Beat storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q  <= {PtrWidth{1'b0}};
            wr_ptr_q  <= {PtrWidth{1'b0}};
            usage_q   <= {CntWidth{1'b0}};
            pkt_cnt_q <= {CntWidth{1'b0}};
            rdy_en_q  <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            usage_q   <= usage_d;
            pkt_cnt_q <= pkt_cnt_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

    axi_stream_buffer_checker #(
        .Depth    (Depth),
        .CntWidth (CntWidth),
        .TWidth   ($bits(s_chan_t))
    ) u_checker (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .rx_valid_i (rx_req_i.tvalid),
        .rx_ready_i (tready_s),
        .rx_t_i     (rx_req_i.t),
        .tx_valid_i (tvalid_s),
        .tx_ready_i (tx_rsp_i.tready),
        .tx_t_i     (tx_req_o.t),
        .usage_i    (usage_q),
        .pkt_cnt_i  (pkt_cnt_q)
    );

endmodule

// File: tb/tb_axi_stream_buffer.sv
// Bench for axi_stream_buffer: three instances (D4 stream, D8 packet, D4 packet) checked
// every cycle against a queue-based reference model.

module tb_axi_stream_buffer;
    import axi_stream_buffer_pkg::*;

    localparam int  DEP [3] = '{4, 8, 4};
    localparam bit  PM  [3] = '{1'b0, 1'b1, 1'b1};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            rx_valid = 1'b0;
    logic            tx_ready = 1'b0;
    s_chan_t         rx_t = '0;
    int              sel = 0;

    axi_stream_req_t rx_req [3];
    axi_stream_rsp_t rx_rsp [3];
    axi_stream_req_t tx_req [3];
    axi_stream_rsp_t tx_rsp [3];
    logic [2:0]      usage0, usage2, pkt0, pkt2;
    logic [3:0]      usage1, pkt1;

    s_chan_t         mq [3][$];
    bit              m_rdy = 1'b0;
    bit              acc = 1'b0;
    int              tests = 0;
    int              fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_drv
        assign rx_req[g].t      = rx_t;
        assign rx_req[g].tvalid = rx_valid && (sel == g);
        assign tx_rsp[g].tready = tx_ready && (sel == g);
    end

    axi_stream_buffer #(.Depth(4), .PacketMode(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .rx_req_i(rx_req[0]), .rx_rsp_o(rx_rsp[0]), .tx_req_o(tx_req[0]), .tx_rsp_i(tx_rsp[0]),
        .usage_o(usage0), .pkt_cnt_o(pkt0));

    axi_stream_buffer #(.Depth(8), .PacketMode(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .rx_req_i(rx_req[1]), .rx_rsp_o(rx_rsp[1]), .tx_req_o(tx_req[1]), .tx_rsp_i(tx_rsp[1]),
        .usage_o(usage1), .pkt_cnt_o(pkt1));

    axi_stream_buffer #(.Depth(4), .PacketMode(1'b1)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .rx_req_i(rx_req[2]), .rx_rsp_o(rx_rsp[2]), .tx_req_o(tx_req[2]), .tx_rsp_i(tx_rsp[2]),
        .usage_o(usage2), .pkt_cnt_o(pkt2));

    function automatic int get_usage(input int k);
        case (k)
            0:       return int'(usage0);
            1:       return int'(usage1);
            default: return int'(usage2);
        endcase
    endfunction

    function automatic int get_pkt(input int k);
        case (k)
            0:       return int'(pkt0);
            1:       return int'(pkt1);
            default: return int'(pkt2);
        endcase
    endfunction

    // Reference model: stored beats are a queue; status is derived from its contents.
    function automatic int m_pkts(input int k);
        int n = 0;
        foreach (mq[k][i]) if (mq[k][i].last) n++;
        return n;
    endfunction

    function automatic bit m_tvalid(input int k);
        int sz = mq[k].size();
        return (sz != 0) && (!PM[k] || (m_pkts(k) != 0) || (sz == DEP[k]));
    endfunction

    function automatic bit m_tready(input int k);
        return m_rdy && (mq[k].size() != DEP[k]) && !flush;
    endfunction

    function automatic s_chan_t mk_beat(input bit last);
        s_chan_t b;
        b.data = $urandom;
        b.strb = 4'($urandom);
        b.keep = 4'($urandom);
        b.last = last;
        b.id   = 4'($urandom);
        b.dest = 4'($urandom);
        b.user = 4'($urandom);
        return b;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input s_chan_t obs, input s_chan_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: compare all instances at the negedge, then advance the model.
    task automatic step();
        bit mv;
        bit mr;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            mv = m_tvalid(k);
            chk($sformatf("usage%0d", k), get_usage(k), mq[k].size());
            chk($sformatf("pkt_cnt%0d", k), get_pkt(k), m_pkts(k));
            chk($sformatf("tvalid%0d", k), int'(tx_req[k].tvalid), int'(mv));
            chk($sformatf("tready%0d", k), int'(rx_rsp[k].tready), int'(m_tready(k)));
            if (mv) chk_beat($sformatf("tdata%0d", k), tx_req[k].t, mq[k][0]);
        end
        acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mv = m_tvalid(k);
            mr = m_tready(k);
            if (!rst_n || flush) begin
                mq[k].delete();
            end else begin
                if (mv && tx_ready && sel == k) void'(mq[k].pop_front());
                if (mr && rx_valid && sel == k) begin
                    mq[k].push_back(rx_t);
                    acc = 1'b1;
                end
            end
        end
        m_rdy = rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input s_chan_t b);
        rx_valid = 1'b1;
        rx_t     = b;
        acc      = 1'b0;
        for (int n = 0; n < 64 && !acc; n++) step();
        chk("push_accept", int'(acc), 1);
    endtask

    task automatic drain(input int k);
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        for (int n = 0; n < 64 && mq[k].size() != 0; n++) step();
        chk("drain_empty", mq[k].size(), 0);
        step();
    endtask

    initial begin
        int cyc;
        // Reset state and release.
        step();
        step();
        rst_n = 1'b1;
        step();

        // Back-to-back streaming, 16 beats, one accepted per cycle.
        sel = 0;
        tx_ready = 1'b1;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            rx_valid = 1'b1;
            rx_t = mk_beat(1'($urandom_range(0, 1)));
            step();
            cyc++;
            if (!acc) begin
                rx_t = rx_t;
                for (int n = 0; n < 8 && !acc; n++) begin step(); cyc++; end
            end
        end
        chk("stream_cycles", cyc, 16);
        drain(0);

        // Fill with backpressure, single pop, beat 5 waits a further cycle.
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_beat(mk_beat(1'b0));
        rx_valid = 1'b1;
        rx_t = mk_beat(1'b0);
        step();
        chk("full_hold", int'(acc), 0);
        tx_ready = 1'b1;
        step();
        chk("pop_cycle_no_push", int'(acc), 0);
        tx_ready = 1'b0;
        step();
        chk("push_after_pop", int'(acc), 1);
        rx_t = mk_beat(1'b1);
        step();
        tx_ready = 1'b1;
        push_beat(rx_t);
        drain(0);

        // Packet mode: held back until tlast is stored.
        sel = 1;
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_beat(mk_beat(1'b0));
        push_beat(mk_beat(1'b1));
        chk("pkt_usage", get_usage(1) + 0, mq[1].size());
        drain(1);

        // Oversize packet on a depth-4 packet-mode buffer.
        sel = 2;
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_beat(mk_beat(i == 5));
        drain(2);

        // Flush drops stored beats; the next beat is output first.
        sel = 0;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_beat(mk_beat(i == 1));
        rx_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("flush_usage", get_usage(0), 0);
        push_beat(mk_beat(1'b1));
        drain(0);

        // Randomised traffic per instance, finished off by a flush.
        for (int k = 0; k < 3; k++) begin
            sel = k;
            acc = 1'b0;
            rx_valid = 1'b0;
            for (int n = 0; n < 150; n++) begin
                if (!rx_valid || acc) begin
                    rx_valid = ($urandom_range(0, 3) != 0);
                    rx_t = mk_beat(($urandom_range(0, 3) == 0));
                end
                tx_ready = ($urandom_range(0, 3) != 0);
                flush = ($urandom_range(0, 39) == 0);
                step();
            end
            flush = 1'b0;
            tx_ready = 1'b1;
            for (int n = 0; n < 32 && rx_valid && !acc; n++) step();
            rx_valid = 1'b0;
            flush = 1'b1;
            step();
            flush = 1'b0;
            step();
        end

        // Asynchronous reset in the middle of a stream.
        sel = 0;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_beat(mk_beat(1'b1));
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_tvalid", int'(tx_req[0].tvalid), 0);
        chk("rst_tready", int'(rx_rsp[0].tready), 0);
        chk("rst_usage", get_usage(0), 0);
        chk("rst_pkt", get_pkt(0), 0);
        for (int k = 0; k < 3; k++) mq[k].delete();
        m_rdy = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        tx_ready = 1'b1;
        push_beat(mk_beat(1'b0));
        push_beat(mk_beat(1'b1));
        drain(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
